// File: rtl/mux_4to1_stream_rr_pkg.sv
//============================================================================
// Package : mux_4to1_stream_rr_pkg
// Desc    : Channel constants and data-slice helper shared by the 4:1 stream
//           mux and the matching 1:4 demux.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

package mux_4to1_stream_rr_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    // Pointer value that makes channel 0 the first candidate after reset.
    localparam logic [SEL_W-1:0] LAST_GRANT_RST = SEL_W'(NUM_CH - 1);

    // LSB of channel ch inside a flattened NUM_CH*data_w bus.
    function automatic int unsigned ch_lsb(input int unsigned ch,
                                           input int unsigned data_w);
        return ch * data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_4to1_stream_rr_arbiter.sv
//============================================================================
// Module : rr_arbiter_4
// Desc   : Four-requester arbiter, one-hot and encoded grant outputs.
//          Round-robin from last_grant+1 by default; fixed priority
//          (channel 0 highest) when MUX_FIXED_PRIO_EN is defined.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module rr_arbiter_4
    import mux_4to1_stream_rr_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last_grant,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_vld
);

`ifdef MUX_FIXED_PRIO_EN

    logic w_unused_last_grant;
    assign w_unused_last_grant = ^last_grant;

    // Descending scan: the lowest-numbered requester is written last and wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[k]) begin
                grant_idx = SEL_W'(k);
                grant_vld = 1'b1;
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

`else

    logic [SEL_W-1:0] w_cand;

    // Scan offsets 4..1 so the nearest candidate after last_grant wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        w_cand    = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_cand = last_grant + SEL_W'(k);
            if (req[w_cand]) begin
                grant_idx = w_cand;
                grant_vld = 1'b1;
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

`endif

endmodule

`default_nettype wire

// File: rtl/mux_4to1_stream_rr.sv
//============================================================================
// Module : mux_4to1_stream_rr
// Desc   : Merges four valid/ready channels onto one registered output
//          stream; out_sel carries the source channel index.
//          Config macro MUX_FIXED_PRIO_EN: fixed priority, no rotating pointer.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module mux_4to1_stream_rr
    import mux_4to1_stream_rr_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [SEL_W-1:0]    r_out_sel;

    logic                w_load_en;
    logic                w_xfer_in;
    logic [NUM_CH-1:0]   w_grant;
    logic [SEL_W-1:0]    w_grant_idx;
    logic                w_grant_vld;
    logic [SEL_W-1:0]    w_last_grant;
    logic [DATA_W-1:0]   w_ch_data [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch_slice
        assign w_ch_data[i] = in_data[ch_lsb(i, DATA_W) +: DATA_W];
    end

    rr_arbiter_4 u_arb (
        .req        (in_valid),
        .last_grant (w_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .grant_vld  (w_grant_vld)
    );

    // The register may take a new word when empty or when its word leaves now.
    assign w_load_en = ~r_out_valid | out_ready;
    assign in_ready  = w_grant & {NUM_CH{w_load_en}};
    assign w_xfer_in = w_grant_vld & w_load_en;

`ifdef MUX_FIXED_PRIO_EN
    assign w_last_grant = LAST_GRANT_RST;
`else
    logic [SEL_W-1:0] r_last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= LAST_GRANT_RST;
        end else if (w_xfer_in) begin
            r_last_grant <= w_grant_idx;
        end
    end

    assign w_last_grant = r_last_grant;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_xfer_in) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_ch_data[w_grant_idx];
            r_out_sel   <= w_grant_idx;
        end else if (out_ready) begin
            // Word consumed with nothing to replace it; data/sel are retained.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_mux_4to1_stream_rr.sv
//============================================================================
// Module : tb_mux_4to1_stream_rr
// Desc   : Scoreboard bench for mux_4to1_stream_rr (honours MUX_FIXED_PRIO_EN).
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_mux_4to1_stream_rr;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst_n;
    logic [3:0]          in_valid;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
    logic                out_ready;

    mux_4to1_stream_rr #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [1:0]        s;
    } word_t;

    word_t             q[$];
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        m_sel;
    logic [1:0]        m_last;
    int                n_chk;
    int                n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input logic [1:0] last);
`ifdef MUX_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (int'(last) + k) % 4;
            if (v[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = '0;
        m_last  = 2'd3;
    endtask

    // Called in the low clock phase after inputs are driven; ends at next negedge.
    task automatic cycle();
        logic [3:0] er;
        logic       load;
        int         g;
        word_t      w;
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_sel", 32'(out_sel), 32'(m_sel));
        if (rst_n) begin
            load = !m_valid || out_ready;
            g    = pick(in_valid, m_last);
            er   = (g >= 0 && load) ? 4'(1 << g) : 4'b0000;
            chk("in_ready", 32'(in_ready), 32'(er));
            if (m_valid && out_ready) begin
                w = q.pop_front();
                chk("sb_word", 32'({out_data, out_sel}), 32'(w));
                m_valid = 1'b0;
            end
            if (er != 4'b0000) begin
                m_data  = in_data[g*DATA_W +: DATA_W];
                m_sel   = 2'(g);
                m_last  = 2'(g);
                m_valid = 1'b1;
                q.push_back({m_data, m_sel});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (2) cycle();
        rst_n = 1'b1;

        // Round-robin with all channels valid, full throughput
        in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        repeat (6) cycle();

        // Load A5 from the next channel, then stall it for five cycles
        in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        cycle();
        out_ready = 1'b0;
        repeat (5) cycle();
        out_ready = 1'b1;
        repeat (3) cycle();

        // Sparse: ch2 alone, then ch1 joins
        in_data  = {8'h00, 8'h7E, 8'h5C, 8'h00};
        in_valid = 4'b0100;
        repeat (4) cycle();
        in_valid = 4'b0110;
        repeat (6) cycle();

        // Drain: one word from ch3 then nothing
        in_valid = 4'b0000;
        repeat (2) cycle();
        in_data  = {8'hD3, 8'h00, 8'h00, 8'h00};
        in_valid = 4'b1000;
        cycle();
        in_valid = 4'b0000;
        repeat (3) cycle();

        // Fixed-priority style check: drop ch0
        in_data  = {8'h3C, 8'h2B, 8'h1A, 8'h09};
        in_valid = 4'b1110;
        repeat (4) cycle();

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Asynchronous reset while a word is held
        in_valid  = 4'b1111;
        in_data   = {8'h88, 8'h77, 8'h66, 8'h55};
        out_ready = 1'b0;
        repeat (2) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_data", 32'(out_data), 32'd0);
        chk("rst_async_sel", 32'(out_sel), 32'd0);
        model_reset();
        in_valid = 4'b0000;
        @(negedge clk);
        repeat (2) cycle();
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        repeat (5) cycle();

        in_valid = 4'b0000;
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
